// File: rtl/lcd_rgb_rx.sv
// Receive side of the RGB LCD bus. It recovers pixel coordinates, measures the
// active resolution and per-frame checksum, and flags lock and line-length errors.
module lcd_rgb_rx #(
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic        lcd_hs,
    input  logic        lcd_vs,
    input  logic        lcd_de,
    input  logic [23:0] lcd_rgb,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic [10:0] pix_xpos,
    output logic [10:0] pix_ypos,
    output logic        frame_start,
    output logic        frame_done,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic [23:0] frame_sum,
    output logic        line_err,
    output logic        locked
);

    localparam logic [10:0] CNT_MAX = 11'd2047;

    typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} state_e;

    state_e      state_q, state_d;

    logic        hs_r1_q, vs_r1_q, vs_r2_q, de_r1_q, de_r2_q;
    logic [23:0] rgb_r1_q;

    logic [10:0] x_q, x_d, y_q, y_d, ref_q, ref_d;
    logic [23:0] sum_q, sum_d;
    logic        bad_q, bad_d;
    logic        prev_bad_q, prev_bad_d, have_prev_q, have_prev_d;

    logic        pix_valid_q, pix_valid_d;
    logic [23:0] pix_data_q, pix_data_d;
    logic [10:0] pix_xpos_q, pix_xpos_d, pix_ypos_q, pix_ypos_d;
    logic        frame_start_q, frame_start_d, frame_done_q, frame_done_d;
    logic        line_err_q, line_err_d, locked_q, locked_d;
    logic [10:0] h_disp_q, h_disp_d, v_disp_q, v_disp_d;
    logic [23:0] frame_sum_q, frame_sum_d;

    logic vs_act_r1, vs_act_r2, vs_rise, de_rise, de_fall;
    logic pix_emit, line_close;

    // Line sync is captured alongside the other bus signals; nothing depends on it.
    logic unused_hs;
    assign unused_hs = (hs_r1_q == HS_POL);

    assign vs_act_r1 = (vs_r1_q == VS_POL);
    assign vs_act_r2 = (vs_r2_q == VS_POL);
    assign vs_rise   = vs_act_r1 & ~vs_act_r2;
    assign de_rise   = de_r1_q & ~de_r2_q;
    assign de_fall   = ~de_r1_q & de_r2_q;

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            hs_r1_q  <= ~HS_POL;
            vs_r1_q  <= ~VS_POL;
            vs_r2_q  <= ~VS_POL;
            de_r1_q  <= 1'b0;
            de_r2_q  <= 1'b0;
            rgb_r1_q <= 24'd0;
        end else begin
            hs_r1_q  <= lcd_hs;
            vs_r1_q  <= lcd_vs;
            vs_r2_q  <= vs_r1_q;
            de_r1_q  <= lcd_de;
            de_r2_q  <= de_r1_q;
            rgb_r1_q <= lcd_rgb;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (vs_rise) begin
            state_d = VBLANK;
        end else begin
            case (state_q)
                VBLANK, HBLANK: if (de_rise) state_d = ACTIVE;
                ACTIVE:         if (de_fall) state_d = HBLANK;
                default:        state_d = state_q;
            endcase
        end
    end

    // A DE that is already high when the frame opens is not a pixel; only a DE edge starts a line.
    assign pix_emit   = ~vs_rise & de_r1_q &
                        ((state_q == ACTIVE) ||
                         (((state_q == VBLANK) || (state_q == HBLANK)) && de_rise));
    assign line_close = (state_q == ACTIVE) & de_fall;

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        ref_d         = ref_q;
        sum_d         = sum_q;
        bad_d         = bad_q;
        prev_bad_d    = prev_bad_q;
        have_prev_d   = have_prev_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_xpos_d    = pix_xpos_q;
        pix_ypos_d    = pix_ypos_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = 1'b0;
        locked_d      = locked_q;
        h_disp_d      = h_disp_q;
        v_disp_d      = v_disp_q;
        frame_sum_d   = frame_sum_q;

        if (pix_emit) begin
            pix_valid_d = 1'b1;
            pix_data_d  = rgb_r1_q;
            pix_xpos_d  = x_q;
            pix_ypos_d  = y_q;
            sum_d       = sum_q + rgb_r1_q;
            if (x_q != CNT_MAX)        x_d   = x_q + 11'd1;
            if (x_q >= CNT_MAX - 11'd1) bad_d = 1'b1;
        end

        if (line_close) begin
            x_d = 11'd0;
            if (y_q != CNT_MAX)         y_d   = y_q + 11'd1;
            if (y_q >= CNT_MAX - 11'd1) bad_d = 1'b1;
            if (y_q == 11'd0) begin
                ref_d = x_q;
            end else if (x_q != ref_q) begin
                line_err_d = 1'b1;
                bad_d      = 1'b1;
            end
        end

        // Frame close sees the line-close results above, so a coincident DE fall counts.
        if (vs_rise) begin
            frame_start_d = 1'b1;
            if ((state_q != IDLE) && (y_d != 11'd0)) begin
                frame_done_d = 1'b1;
                h_disp_d     = ref_d;
                v_disp_d     = y_d;
                frame_sum_d  = sum_d;
                locked_d     = ~bad_d & have_prev_q & ~prev_bad_q &
                               (ref_d == h_disp_q) & (y_d == v_disp_q);
                prev_bad_d   = bad_d;
                have_prev_d  = 1'b1;
            end
            x_d   = 11'd0;
            y_d   = 11'd0;
            ref_d = 11'd0;
            sum_d = 24'd0;
            bad_d = 1'b0;
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= 11'd0;
            y_q           <= 11'd0;
            ref_q         <= 11'd0;
            sum_q         <= 24'd0;
            bad_q         <= 1'b0;
            prev_bad_q    <= 1'b0;
            have_prev_q   <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= 24'd0;
            pix_xpos_q    <= 11'd0;
            pix_ypos_q    <= 11'd0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            locked_q      <= 1'b0;
            h_disp_q      <= 11'd0;
            v_disp_q      <= 11'd0;
            frame_sum_q   <= 24'd0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            ref_q         <= ref_d;
            sum_q         <= sum_d;
            bad_q         <= bad_d;
            prev_bad_q    <= prev_bad_d;
            have_prev_q   <= have_prev_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_xpos_q    <= pix_xpos_d;
            pix_ypos_q    <= pix_ypos_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            locked_q      <= locked_d;
            h_disp_q      <= h_disp_d;
            v_disp_q      <= v_disp_d;
            frame_sum_q   <= frame_sum_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_xpos    = pix_xpos_q;
    assign pix_ypos    = pix_ypos_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign locked      = locked_q;
    assign h_disp      = h_disp_q;
    assign v_disp      = v_disp_q;
    assign frame_sum   = frame_sum_q;

endmodule
